// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-set round-robin replacement and a set-walking flush.
// Define BTB_ASSOC_READ_REG_EN to register the lookup outputs (1-cycle latency).
module btb_assoc #(
    parameter int XLEN     = 32,
    parameter int SET_BITS = 4,
    parameter int WAYS     = 2,
    parameter int OFFSET   = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                flush_i,
    output logic                                flush_busy_o,
    input  logic [XLEN-1:0]                     pc_i,
    input  logic                                valid_i,
    input  logic                                del_entry_i,
    input  logic [XLEN-1:0]                     res_pc_i,
    input  logic [XLEN-1:0]                     res_target_i,
    output logic                                hit_o,
    output logic [XLEN-1:0]                     pred_target_o,
    output logic [(WAYS > 1 ? $clog2(WAYS) : 1)-1:0] hit_way_o
);
    localparam int SETS = 1 << SET_BITS;
    localparam int TW   = XLEN - SET_BITS - OFFSET;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WW-1:0] LAST_WAY = WW'(WAYS - 1);

    typedef enum logic {IDLE, WALK} state_e;

    state_e                      state_q;
    logic [SET_BITS-1:0]         fcnt_q;
    logic [SETS-1:0][WAYS-1:0]   valid_q;
    logic [WW-1:0]               rr_q  [SETS];
    logic [TW-1:0]               tag_q [SETS][WAYS];
    logic [XLEN-1:0]             tgt_q [SETS][WAYS];

    logic                        walk;
    assign walk         = (state_q == WALK);
    assign flush_busy_o = walk;

    // Lookup, read from registered state only
    logic [SET_BITS-1:0] lk_set;
    logic [TW-1:0]       lk_tag;
    logic                lk_hit;
    logic [WW-1:0]       lk_way;
    logic [XLEN-1:0]     lk_tgt;

    assign lk_set = pc_i[SET_BITS+OFFSET-1:OFFSET];
    assign lk_tag = pc_i[XLEN-1:SET_BITS+OFFSET];

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        lk_tgt = '0;
        // Descending scan so the lowest matching way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = WW'(w);
                lk_tgt = tgt_q[lk_set][w];
            end
        end
    end

    // Update-side match / free-way search
    logic [SET_BITS-1:0] up_set;
    logic [TW-1:0]       up_tag;
    logic                m_hit;
    logic [WW-1:0]       m_way;
    logic                f_any;
    logic [WW-1:0]       f_way;
    logic [WW-1:0]       ins_way;
    logic                up_en;
    logic                data_we;

    assign up_set = res_pc_i[SET_BITS+OFFSET-1:OFFSET];
    assign up_tag = res_pc_i[XLEN-1:SET_BITS+OFFSET];

    always_comb begin
        m_hit = 1'b0;
        m_way = '0;
        f_any = 1'b0;
        f_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
                m_hit = 1'b1;
                m_way = WW'(w);
            end
            if (!valid_q[up_set][w]) begin
                f_any = 1'b1;
                f_way = WW'(w);
            end
        end
    end

    assign up_en   = valid_i && !walk && !flush_i;
    assign data_we = up_en && !del_entry_i;
    assign ins_way = m_hit ? m_way : (f_any ? f_way : rr_q[up_set]);

    // Flush FSM plus valid/rr state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q <= WALK;
                        fcnt_q  <= '0;
                    end else if (up_en) begin
                        if (m_hit) begin
                            if (del_entry_i) valid_q[up_set][m_way] <= 1'b0;
                        end else if (!del_entry_i) begin
                            valid_q[up_set][ins_way] <= 1'b1;
                            if (!f_any)
                                rr_q[up_set] <= (rr_q[up_set] == LAST_WAY) ? '0 : rr_q[up_set] + 1'b1;
                        end
                    end
                end
                WALK: begin
                    valid_q[fcnt_q] <= '0;
                    rr_q[fcnt_q]    <= '0;
                    if (flush_i) begin
                        fcnt_q <= '0;
                    end else if (fcnt_q == SET_BITS'(SETS - 1)) begin
                        state_q <= IDLE;
                        fcnt_q  <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/target payload needs no reset; valid bits gate it
    always_ff @(posedge clk_i) begin
        if (data_we) begin
            tag_q[up_set][ins_way] <= up_tag;
            tgt_q[up_set][ins_way] <= res_target_i;
        end
    end

`ifdef BTB_ASSOC_READ_REG_EN
    logic            hit_q;
    logic [XLEN-1:0] tgt_o_q;
    logic [WW-1:0]   way_q;
    logic            lk_ok;

    assign lk_ok = lk_hit && !walk && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_q   <= 1'b0;
            tgt_o_q <= '0;
            way_q   <= '0;
        end else begin
            hit_q   <= lk_ok;
            tgt_o_q <= lk_ok ? lk_tgt : '0;
            way_q   <= lk_ok ? lk_way : '0;
        end
    end

    assign hit_o         = hit_q;
    assign pred_target_o = tgt_o_q;
    assign hit_way_o     = way_q;
`else
    logic lk_ok;
    assign lk_ok         = lk_hit && !walk;
    assign hit_o         = lk_ok;
    assign pred_target_o = lk_ok ? lk_tgt : '0;
    assign hit_way_o     = lk_ok ? lk_way : '0;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc (default parameters, combinational lookup).
module tb_btb_assoc;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        flush_busy_o;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        del_entry_i;
    logic [31:0] res_pc_i;
    logic [31:0] res_target_i;
    logic        hit_o;
    logic [31:0] pred_target_o;
    logic [0:0]  hit_way_o;

    btb_assoc dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .pc_i(pc_i), .valid_i(valid_i), .del_entry_i(del_entry_i), .res_pc_i(res_pc_i),
        .res_target_i(res_target_i), .hit_o(hit_o), .pred_target_o(pred_target_o),
        .hit_way_o(hit_way_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          op;   // 0 update, 1 lookup, 2 reset
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        del;
        logic        eh;
        logic [31:0] et;
        logic [0:0]  ew;
    } vec_t;

    typedef struct {
        logic        eh;
        logic [31:0] et;
        logic [0:0]  ew;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        #3;
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic del);
        valid_i = 1'b1; res_pc_i = pc; res_target_i = tgt; del_entry_i = del;
        step();
        valid_i = 1'b0; del_entry_i = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic eh,
                        input logic [31:0] et, input logic [0:0] ew);
        exp_t e;
        sb.push_back('{eh: eh, et: et, ew: ew});
        pc_i = pc;
        #1;
        e = sb.pop_front();
        chk({name, ".hit"}, {31'd0, hit_o}, {31'd0, e.eh});
        if (e.eh) chk({name, ".tgt"}, pred_target_o, e.et);
        chk({name, ".way"}, {31'd0, hit_way_o}, {31'd0, e.ew});
    endtask

    function automatic void add(int op, logic [31:0] pc, logic [31:0] tgt, logic del,
                                logic eh, logic [31:0] et, logic [0:0] ew);
        tbl.push_back('{op: op, pc: pc, tgt: tgt, del: del, eh: eh, et: et, ew: ew});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; pc_i = 32'h100; valid_i = 1'b0;
        del_entry_i = 1'b0; res_pc_i = '0; res_target_i = '0;

        // Replacement: two ways full, then round-robin victims
        add(2, 0, 0, 0, 0, 0, 0);
        add(0, 32'h100, 32'h1100, 0, 0, 0, 0);
        add(0, 32'h140, 32'h1140, 0, 0, 0, 0);
        add(0, 32'h180, 32'h1180, 0, 0, 0, 0);
        add(1, 32'h180, 0, 0, 1, 32'h1180, 0);
        add(1, 32'h100, 0, 0, 0, 0, 0);
        add(1, 32'h140, 0, 0, 1, 32'h1140, 1);
        add(0, 32'h1C0, 32'h11C0, 0, 0, 0, 0);
        add(1, 32'h1C0, 0, 0, 1, 32'h11C0, 1);
        add(1, 32'h140, 0, 0, 0, 0, 0);
        add(0, 32'h200, 32'h1200, 0, 0, 0, 0);   // rr wrapped to 0
        add(1, 32'h200, 0, 0, 1, 32'h1200, 0);
        add(1, 32'h180, 0, 0, 0, 0, 0);
        add(1, 32'h1C0, 0, 0, 1, 32'h11C0, 1);
        // Overwrite, delete, refill free way, delete absent
        add(2, 0, 0, 0, 0, 0, 0);
        add(0, 32'h100, 32'h1100, 0, 0, 0, 0);
        add(0, 32'h140, 32'h1140, 0, 0, 0, 0);
        add(0, 32'h100, 32'h300, 0, 0, 0, 0);
        add(1, 32'h100, 0, 0, 1, 32'h300, 0);
        add(1, 32'h140, 0, 0, 1, 32'h1140, 1);
        add(0, 32'h140, 0, 1, 0, 0, 0);
        add(1, 32'h140, 0, 0, 0, 0, 0);
        add(0, 32'h180, 32'h1180, 0, 0, 0, 0);
        add(1, 32'h180, 0, 0, 1, 32'h1180, 1);
        add(1, 32'h100, 0, 0, 1, 32'h300, 0);
        add(0, 32'h1C0, 0, 1, 0, 0, 0);
        add(1, 32'h1C0, 0, 0, 0, 0, 0);
        add(1, 32'h180, 0, 0, 1, 32'h1180, 1);
        add(1, 32'h100, 0, 0, 1, 32'h300, 0);
        // Different set with same tag as set 0 entries
        add(1, 32'h104, 0, 0, 0, 0, 0);

        #2;
        rst_n_i = 1'b1;
        step();
        chk("rst.busy", {31'd0, flush_busy_o}, 32'd0);
        look("rst", 32'h100, 0, 0, 0);

        // Update not visible before its edge, visible after
        valid_i = 1'b1; res_pc_i = 32'h100; res_target_i = 32'h200; del_entry_i = 1'b0;
        look("nofwd", 32'h100, 0, 0, 0);
        step();
        valid_i = 1'b0;
        look("first", 32'h100, 1, 32'h200, 0);
        look("othertag", 32'h140, 0, 0, 0);
        step();

        foreach (tbl[i]) begin
            case (tbl[i].op)
                0: upd(tbl[i].pc, tbl[i].tgt, tbl[i].del);
                1: begin
                    look($sformatf("vec%0d", i), tbl[i].pc, tbl[i].eh, tbl[i].et, tbl[i].ew);
                    step();
                end
                default: do_reset();
            endcase
        end

        // Flush with a simultaneous update that must be dropped
        do_reset();
        upd(32'h100, 32'hA100, 0);
        upd(32'h108, 32'hA108, 0);
        upd(32'h10C, 32'hA10C, 0);
        look("preflush", 32'h10C, 1, 32'hA10C, 0);
        flush_i = 1'b1; valid_i = 1'b1; res_pc_i = 32'h104; res_target_i = 32'h999;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("walk%0d.busy", c), {31'd0, flush_busy_o}, 32'd1);
            look($sformatf("walk%0d", c), 32'h10C, 0, 0, 0);
            step();
        end
        chk("walkend.busy", {31'd0, flush_busy_o}, 32'd0);
        look("postflush100", 32'h100, 0, 0, 0);
        look("postflush104", 32'h104, 0, 0, 0);
        look("postflush108", 32'h108, 0, 0, 0);
        look("postflush10C", 32'h10C, 0, 0, 0);
        step();

        // Re-pulse at walk cycle 5 restarts the 16-cycle walk
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("restart.pre", {31'd0, flush_busy_o}, 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        begin
            int n = 0;
            while (flush_busy_o && n < 40) begin
                n++;
                step();
            end
            chk("restart.len", n, 32'd16);
        end

        // Async reset mid-walk
        upd(32'h100, 32'hB100, 0);
        look("prerst", 32'h100, 1, 32'hB100, 0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step(); step();
        chk("midwalk.busy", {31'd0, flush_busy_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("rstwalk.busy", {31'd0, flush_busy_o}, 32'd0);
        look("rstwalk", 32'h100, 0, 0, 0);
        rst_n_i = 1'b1;
        step();
        chk("afterrst.busy", {31'd0, flush_busy_o}, 32'd0);
        look("afterrst", 32'h100, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
